// File: rtl/blackjack_auto_player_if.sv
// blackjack_auto_player_if: signal bundle between the auto player and its card source, game core and host.
//   master : the auto player (drives card_ready, game-core controls, status and statistics)
//   slave  : the surrounding system (drives start, opening cards, game sums and result flags)
interface blackjack_auto_player_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             card_valid;
    logic             card_ready;
    logic [4:0]       card_data;
    logic [5:0]       player_sum;
    logic [5:0]       dealer_sum;
    logic             win;
    logic             lose;
    logic             draw;
    logic             game_reset;
    logic [4:0]       seed;
    logic [4:0]       card_in;
    logic             submit;
    logic             hit;
    logic             stand;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] games;
    logic [CNT_W-1:0] wins;
    logic [CNT_W-1:0] losses;
    logic [CNT_W-1:0] draws;

    modport master (
        input  start, card_valid, card_data, player_sum, dealer_sum, win, lose, draw,
        output card_ready, game_reset, seed, card_in, submit, hit, stand,
               busy, done, err, games, wins, losses, draws
    );

    modport slave (
        output start, card_valid, card_data, player_sum, dealer_sum, win, lose, draw,
        input  card_ready, game_reset, seed, card_in, submit, hit, stand,
               busy, done, err, games, wins, losses, draws
    );
endinterface

// File: rtl/blackjack_auto_player.sv
// blackjack_auto_player: unattended blackjack bot that resets the game core, deals two opening cards,
// hits below STAND_AT, paces dealer draws and tallies saturating win/loss/draw statistics.
//   clk   : system clock
//   reset : asynchronous active-high reset (shared with the game core)
//   bus   : master side of blackjack_auto_player_if (card handshake, game-core controls, status, counters)
module blackjack_auto_player #(
    parameter int STAND_AT = 17,
    parameter int GAP      = 2,
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input logic                     clk,
    input logic                     reset,
    blackjack_auto_player_if.master bus
);
    localparam int CW = $clog2(GAP + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [3:0] {
        IDLE, GRST, SETTLE, OPEN, WAIT, DEAL1, DEAL2, FEED, DECIDE, HIT, STAND, DRAIN, RECORD
    } state_t;

    state_t           state_q, nxt_q;
    logic [CW-1:0]    cnt_q;
    logic [WW-1:0]    wt_q;
    logic             card_ready_q, game_reset_q, submit_q, hit_q, stand_q, busy_q, done_q, err_q;
    logic [4:0]       seed_q, card_in_q;
    logic [CNT_W-1:0] games_q, wins_q, losses_q, draws_q;
    logic             result;

    assign result         = bus.win | bus.lose | bus.draw;
    assign bus.card_ready = card_ready_q;
    assign bus.game_reset = game_reset_q;
    assign bus.seed       = seed_q;
    assign bus.card_in    = card_in_q;
    assign bus.submit     = submit_q;
    assign bus.hit        = hit_q;
    assign bus.stand      = stand_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.games      = games_q;
    assign bus.wins       = wins_q;
    assign bus.losses     = losses_q;
    assign bus.draws      = draws_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_W'(1);
    endfunction

    // Outputs are loaded on the transition into the state they belong to, so each pulse is
    // high for exactly the cycle its state occupies. nxt_q tells WAIT where to resume after a gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            nxt_q        <= IDLE;
            cnt_q        <= '0;
            wt_q         <= '0;
            card_ready_q <= 1'b0;
            game_reset_q <= 1'b0;
            submit_q     <= 1'b0;
            hit_q        <= 1'b0;
            stand_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            seed_q       <= 5'd1;
            card_in_q    <= '0;
            games_q      <= '0;
            wins_q       <= '0;
            losses_q     <= '0;
            draws_q      <= '0;
        end else begin
            card_ready_q <= 1'b0;
            game_reset_q <= 1'b0;
            submit_q     <= 1'b0;
            hit_q        <= 1'b0;
            stand_q      <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q      <= GRST;
                    game_reset_q <= 1'b1;
                    busy_q       <= 1'b1;
                    err_q        <= 1'b0;
                    seed_q       <= seed_q == 5'd31 ? 5'd1 : seed_q + 5'd1;
                end
                GRST: state_q <= SETTLE;
                SETTLE: begin
                    state_q  <= OPEN;
                    nxt_q    <= DEAL1;
                    submit_q <= 1'b1;
                end
                OPEN, FEED, HIT: begin
                    state_q <= WAIT;
                    cnt_q   <= CW'(GAP - 1);
                end
                WAIT: begin
                    state_q <= cnt_q == '0 ? nxt_q : WAIT;
                    cnt_q   <= cnt_q - CW'(1);
                end
                // Ready is registered: the card sampled here is presented (with submit) in FEED,
                // which is the handshake cycle while the source still holds valid and data.
                DEAL1, DEAL2: if (bus.card_valid) begin
                    state_q      <= FEED;
                    nxt_q        <= state_q == DEAL1 ? DEAL2 : DECIDE;
                    card_ready_q <= 1'b1;
                    submit_q     <= 1'b1;
                    card_in_q    <= bus.card_data;
                end
                DECIDE: begin
                    if (result) begin
                        state_q <= RECORD;
                    end else if (bus.player_sum > 6'd21) begin
                        state_q  <= DRAIN;
                        submit_q <= 1'b1;
                        cnt_q    <= '0;
                        wt_q     <= '0;
                    end else if (bus.player_sum >= 6'(STAND_AT)) begin
                        state_q <= STAND;
                        stand_q <= 1'b1;
                    end else begin
                        state_q  <= HIT;
                        nxt_q    <= DECIDE;
                        hit_q    <= 1'b1;
                        submit_q <= 1'b1;
                    end
                end
                STAND: begin
                    state_q  <= DRAIN;
                    submit_q <= 1'b1;
                    cnt_q    <= '0;
                    wt_q     <= '0;
                end
                // cnt_q is the phase within a GAP+1 cycle submit period; wt_q counts DRAIN cycles.
                DRAIN: begin
                    if (result) begin
                        state_q <= RECORD;
                    end else if (wt_q == WW'(MAX_WAIT - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wt_q     <= wt_q + WW'(1);
                        cnt_q    <= cnt_q == CW'(GAP) ? '0 : cnt_q + CW'(1);
                        submit_q <= cnt_q == CW'(GAP);
                    end
                end
                RECORD: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    games_q  <= sat_inc(games_q);
                    draws_q  <= bus.draw ? sat_inc(draws_q) : draws_q;
                    wins_q   <= !bus.draw && bus.win ? sat_inc(wins_q) : wins_q;
                    losses_q <= !bus.draw && !bus.win ? sat_inc(losses_q) : losses_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blackjack_auto_player.sv
// tb_blackjack_auto_player: scoreboard bench with a behavioural game-core model driving the auto player.
module tb_blackjack_auto_player;
    localparam int STAND_AT = 17;
    localparam int GAP      = 2;
    localparam int MAX_WAIT = 255;
    localparam int CNT_W    = 8;
    localparam int M_NAT    = 0;
    localparam int M_NORM   = 1;
    localparam int M_NEVER  = 2;

    typedef struct {
        int g;
        int w;
        int l;
        int d;
    } stats_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    blackjack_auto_player_if #(.CNT_W(CNT_W)) bus ();

    blackjack_auto_player #(
        .STAND_AT(STAND_AT),
        .GAP(GAP),
        .MAX_WAIT(MAX_WAIT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int     n_tests = 0;
    int     n_fail = 0;
    int     cyc = 0;
    stats_t sb[$];
    int     mg = 0, mw = 0, ml = 0, md = 0;
    int     exp_seed = 1;
    int     mode = M_NAT;
    int     hit_cards[$];
    logic [2:0] res = 3'b000;
    int     psum = 0, deals = 0, drain_subs = 0, last_sub = 0;
    bit     stood = 1'b0;
    int     hits_seen = 0, stands_seen = 0, stand_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return v >= (1 << CNT_W) - 1 ? (1 << CNT_W) - 1 : v + 1;
    endfunction

    initial forever @(posedge clk) cyc++;

    // Game core model plus pulse monitor, evaluated mid-cycle.
    initial begin
        bus.player_sum = '0;
        bus.dealer_sum = 6'd18;
        {bus.win, bus.lose, bus.draw} = 3'b000;
        forever begin
            @(negedge clk);
            if (bus.hit) begin
                hits_seen++;
                chk("hit_not_stand", bus.stand, 0);
                chk("hit_submit", bus.submit, 1);
            end
            if (bus.game_reset) chk("seed", bus.seed, exp_seed);
            if (bus.game_reset) begin
                psum = 0;
                deals = 0;
                drain_subs = 0;
                stood = 1'b0;
                {bus.win, bus.lose, bus.draw} = 3'b000;
            end else begin
                if (bus.submit && bus.card_ready) begin
                    psum += int'(bus.card_in);
                    deals++;
                    if (deals == 2 && mode == M_NAT) {bus.win, bus.lose, bus.draw} = res;
                end else if (bus.submit && bus.hit) begin
                    psum += hit_cards.size() > 0 ? hit_cards.pop_front() : 0;
                end else if (bus.submit && (stood || psum > 21)) begin
                    if (drain_subs > 0) chk("drain_gap", cyc - last_sub, GAP + 1);
                    last_sub = cyc;
                    drain_subs++;
                    if (mode == M_NORM && drain_subs == 2) {bus.win, bus.lose, bus.draw} = res;
                end
                if (bus.stand) begin
                    stood = 1'b1;
                    stands_seen++;
                    stand_cyc = cyc;
                end
            end
            bus.player_sum = 6'(psum);
        end
    end

    task automatic give(input int c);
        int n = 0;
        bus.card_valid = 1'b1;
        bus.card_data  = 5'(c);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.card_ready && n < 200);
        chk("card_ready", bus.card_ready, 1);
        chk("card_in", bus.card_in, c);
        bus.card_valid = 1'b0;
    endtask

    task automatic play(input int m, input int c1, input int c2, input int h1, input int h2,
                        input bit stall, input bit rw, input bit rl, input bit rd,
                        input int eh, input int es, input bit busy_start);
        stats_t e;
        int n = 0;
        int bad = 0;
        mode = m;
        hit_cards.delete();
        if (h1 != 0) hit_cards.push_back(h1);
        if (h2 != 0) hit_cards.push_back(h2);
        res = {rw, rl, rd};
        if (m != M_NEVER) begin
            mg = sat(mg);
            if (rd) md = sat(md);
            else if (rw) mw = sat(mw);
            else ml = sat(ml);
            sb.push_back('{mg, mw, ml, md});
        end
        exp_seed = exp_seed == 31 ? 1 : exp_seed + 1;
        hits_seen = 0;
        stands_seen = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_clr", bus.err, 0);
        if (stall) begin
            repeat (4) @(negedge clk);
            repeat (20) begin
                @(negedge clk);
                if (bus.submit || bus.card_ready) bad++;
            end
            chk("stall_quiet", bad, 0);
        end
        give(c1);
        if (busy_start) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        give(c2);
        while (!bus.done && !(m == M_NEVER && !bus.busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m == M_NEVER) begin
            chk("timeout_idle", !bus.busy, 1);
            chk("err_set", bus.err, 1);
            chk("drain_len", cyc - stand_cyc, MAX_WAIT + 1);
            chk("cnt_kept", {bus.games, bus.wins, bus.losses, bus.draws},
                {8'(mg), 8'(mw), 8'(ml), 8'(md)});
        end else begin
            chk("done_seen", bus.done, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("games", bus.games, e.g);
                chk("wins", bus.wins, e.w);
                chk("losses", bus.losses, e.l);
                chk("draws", bus.draws, e.d);
            end
            chk("hits", hits_seen, eh);
            chk("stands", stands_seen, es);
            @(negedge clk);
            chk("done_once", bus.done, 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.card_valid = 1'b0;
        bus.card_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {bus.card_ready, bus.game_reset, bus.submit, bus.hit, bus.stand,
                        bus.busy, bus.done, bus.err}, 0);
        chk("rst_seed", bus.seed, 1);
        chk("rst_card_in", bus.card_in, 0);
        chk("rst_cnt", {bus.games, bus.wins, bus.losses, bus.draws}, 0);
        reset = 1'b0;
        @(negedge clk);
        play(M_NAT, 10, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        play(M_NORM, 5, 6, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0);
        play(M_NORM, 10, 6, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        play(M_NORM, 9, 9, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0);
        play(M_NEVER, 10, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
        play(M_NAT, 10, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1);
        for (int i = 0; i < 256; i++) play(M_NAT, 10, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("sat_games", bus.games, 255);
        chk("sat_wins", bus.wins, 255);
        exp_seed = exp_seed == 31 ? 1 : exp_seed + 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_cnt", {bus.games, bus.wins, bus.losses, bus.draws}, 0);
        chk("async_rst_seed", bus.seed, 1);
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/blackjack_auto_player.md
Name: blackjack_auto_player

Overview:
Automated player agent that drives the input side of the blackjack game core and consumes its result outputs. It resets the game, supplies the two opening player cards from an upstream card source, and applies a fixed hit/stand threshold strategy. It pulses submit until a result appears, then tallies wins, losses and draws. It sits between a card source or testbench and the game core, so the game can play batches of unattended rounds.

Parameters:
STAND_AT, 17, bot stands when observed player_sum >= STAND_AT (valid 12..21)
GAP, 2, idle cycles after every submit pulse before the game sums are re-sampled (min 1)
MAX_WAIT, 255, cycles allowed in DRAIN without a result flag before err
CNT_W, 8, width of statistics counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to play one game; ignored unless busy=0
card_valid  in  1  upstream opening-card available
card_data  in  5  opening-card value, passed through unmodified
card_ready  out  1  card accepted this cycle (card_valid & card_ready)
player_sum  in  6  game core player sum
dealer_sum  in  6  game core dealer sum
win  in  1  game result flag
lose  in  1  game result flag
draw  in  1  game result flag
game_reset  out  1  reset pulse to the game core
seed  out  5  LFSR seed to the game core; held stable while game_reset is high
card_in  out  5  card value to the game core
submit  out  1  submit pulse to the game core
hit  out  1  hit request
stand  out  1  stand request
busy  out  1  game in progress
done  out  1  one-cycle pulse when a game is recorded
err  out  1  sticky; set on DRAIN timeout; cleared by reset or the next accepted start
games, wins, losses, draws  out  CNT_W each  saturating statistics counters

Behaviour:
- Reset: all outputs 0, except seed=5'd1. State is IDLE.
- All outputs are registered.
- The seed register increments on every accepted start and skips 0.
- FSM states:
  - IDLE: busy=0. start -> GRST.
  - GRST: game_reset=1 for exactly 1 cycle -> SETTLE.
  - SETTLE: 1 cycle with no outputs asserted -> OPEN.
  - OPEN: submit=1 for 1 cycle; this moves the game core out of its idle state and deals nothing. Then wait GAP cycles -> DEAL1.
  - DEAL1, DEAL2: wait for card_valid. On the handshake cycle, drive card_in=card_data and submit=1 in the same cycle, then wait GAP cycles. While card_valid=0, stall indefinitely with submit=0. card_ready is high only on the handshake cycle. DEAL2 -> DECIDE.
  - DECIDE (one cycle):
    - if win|lose|draw: -> RECORD (opening blackjack path)
    - else if player_sum > 21: -> DRAIN
    - else if player_sum >= STAND_AT: -> STAND
    - else: -> HIT
  - HIT: hit=1 and submit=1 for 1 cycle, then wait GAP cycles -> DECIDE.
  - STAND: stand=1 for 1 cycle -> DRAIN.
  - DRAIN: submit=1 one cycle out of every GAP+1 cycles, to pace dealer draws. hit and stand stay 0. Leaves on the first cycle where win|lose|draw=1 -> RECORD. If MAX_WAIT cycles pass with no flag: set err -> IDLE, no counter updates.
  - RECORD: increment games. Increment exactly one of: draws if draw; else wins if win; else losses. The cycle after RECORD, done pulses and the FSM returns to IDLE.
- Result flags are sampled in DECIDE, DRAIN and RECORD only; they are ignored elsewhere.
- hit, stand and submit are never high outside the cycles listed above. hit and stand are never high together.
- Counters saturate at all-ones and are never cleared except by reset.
- start while busy=1 is dropped.
- Asynchronous reset mid-game returns the FSM to IDLE immediately. Counters are cleared. game_reset is not driven by this reset; the system reset is shared with the game core.
- A card_valid pulse outside DEAL1/DEAL2 is not consumed.

Test Plan:
- Opening cards 10 then 1, game flags win after the second deal -> no hit or stand pulse; wins=1, games=1; done pulses once.
- Cards 5 then 6 (sum 11), STAND_AT=17, core adds cards to reach 19 -> hit+submit pulses until player_sum>=17, then exactly one stand pulse; DRAIN submit pulses spaced GAP+1 cycles apart.
- Player forced to bust (sum 24 after a hit) -> no stand pulse; DRAIN entered; lose flag -> losses=1.
- card_valid held low for 20 cycles in DEAL1 -> submit stays 0 and card_ready stays 0; consumption resumes on valid.
- Core model never raises a result flag -> err set after MAX_WAIT=255 DRAIN cycles; counters unchanged; the next start clears err.
- win and draw asserted together -> draws incremented, wins unchanged; start pulse during busy ignored; counters saturate at 255 after 256 forced wins.
